// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instructions over a
// valid/ready handshake and drives the IF/ID pipeline register. A one-entry
// skid buffer holds a fetched instruction while decode stalls. A pending-target
// register remembers a redirect that arrives while a request is outstanding.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        active_reg;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pending_reg, pending_next;
    logic [31:0] skid_pc4_reg, skid_pc4_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] if_id_pc4_reg, if_id_pc4_next;
    logic [31:0] if_id_instr_reg, if_id_instr_next;
    logic        if_id_valid_reg, if_id_valid_next;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic        transfer;
    logic        load_en;
    logic [31:0] load_pc4;
    logic [31:0] load_instr;

    // active_reg keeps the request low for the first cycle out of reset
    assign imem_req         = active_reg && (state_reg != HOLD);
    assign imem_addr        = pc_reg;
    assign pc_plus4         = pc_reg + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'h3;
    assign transfer         = imem_req & imem_ready;

    assign if_id_pc4   = if_id_pc4_reg;
    assign if_id_instr = if_id_instr_reg;
    assign if_id_valid = if_id_valid_reg;

    // State, PC, buffers and IF/ID register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH;
            active_reg      <= 1'b0;
            pc_reg          <= RESET_PC;
            pending_reg     <= 32'h0;
            skid_pc4_reg    <= 32'h0;
            skid_instr_reg  <= 32'h0;
            if_id_pc4_reg   <= 32'h0;
            if_id_instr_reg <= 32'h0;
            if_id_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            active_reg      <= 1'b1;
            pc_reg          <= pc_next;
            pending_reg     <= pending_next;
            skid_pc4_reg    <= skid_pc4_next;
            skid_instr_reg  <= skid_instr_next;
            if_id_pc4_reg   <= if_id_pc4_next;
            if_id_instr_reg <= if_id_instr_next;
            if_id_valid_reg <= if_id_valid_next;
        end
    end

    // Next-state, PC update and selection of what (if anything) loads IF/ID
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pending_next    = pending_reg;
        skid_pc4_next   = skid_pc4_reg;
        skid_instr_next = skid_instr_reg;
        load_en         = 1'b0;
        load_pc4        = pc_plus4;
        load_instr      = imem_data;
        if (active_reg) begin
            case (state_reg)
                FETCH: begin
                    if (transfer) begin
                        if (redirect_valid) begin
                            // Wrong-path instruction: drop it, go to target
                            pc_next = redirect_aligned;
                        end else if (!stall) begin
                            load_en = 1'b1;
                            pc_next = pc_plus4;
                        end else begin
                            skid_pc4_next   = pc_plus4;
                            skid_instr_next = imem_data;
                            state_next      = HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Address must stay stable until the response returns
                        pending_next = redirect_aligned;
                        state_next   = DRAIN;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc_next    = redirect_aligned;
                        state_next = FETCH;
                    end else if (!stall) begin
                        load_en    = 1'b1;
                        load_pc4   = skid_pc4_reg;
                        load_instr = skid_instr_reg;
                        pc_next    = pc_plus4;
                        state_next = FETCH;
                    end
                end
                DRAIN: begin
                    if (transfer) begin
                        pc_next    = redirect_valid ? redirect_aligned : pending_reg;
                        state_next = FETCH;
                    end else if (redirect_valid) begin
                        pending_next = redirect_aligned;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    // IF/ID register update: flush beats stall beats load; otherwise a bubble
    always_comb begin
        if_id_pc4_next   = if_id_pc4_reg;
        if_id_instr_next = if_id_instr_reg;
        if_id_valid_next = if_id_valid_reg;
        if (flush) begin
            if_id_instr_next = 32'h0;
            if_id_valid_next = 1'b0;
        end else if (stall) begin
            if_id_valid_next = if_id_valid_reg;
        end else if (load_en) begin
            if_id_pc4_next   = load_pc4;
            if_id_instr_next = load_instr;
            if_id_valid_next = 1'b1;
        end else begin
            if_id_instr_next = 32'h0;
            if_id_valid_next = 1'b0;
        end
    end

endmodule
